// File: rtl/led_pwm_frame.sv
// led_pwm_frame: frame-rate PWM pattern generator feeding a 12-bit LED
// shift-register serializer. Duty values are double-buffered (shadow ->
// active) and committed only when the PWM counter wraps, so one PWM
// period never mixes old and new settings.
module led_pwm_frame #(
    parameter int CHANNELS = 12,
    parameter int DUTY_W   = 4
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                wr_en,
    input  logic [3:0]          wr_addr,
    input  logic [DUTY_W-1:0]   wr_data,
    input  logic                frame_tick,
    output logic [CHANNELS-1:0] rgb_x4,
    output logic                period_start,
    output logic                wr_err
);

    localparam logic [DUTY_W-1:0] CNT_MAX = '1;

    logic [DUTY_W-1:0]   shadow [CHANNELS];
    logic [DUTY_W-1:0]   active [CHANNELS];
    logic [DUTY_W-1:0]   pwm_cnt;

    logic                wrap;
    logic                addr_ok;
    logic [DUTY_W-1:0]   next_cnt;
    logic [DUTY_W-1:0]   next_active [CHANNELS];
    logic [CHANNELS-1:0] next_pattern;

    // Next counter, next active bank and the pattern they produce on a tick.
    // NOTE: every always_comb output gets a default before any condition,
    // otherwise a missed branch silently infers a latch.
    always_comb begin
        wrap     = (pwm_cnt == CNT_MAX);
        addr_ok  = (32'(wr_addr) < 32'(CHANNELS));
        next_cnt = wrap ? '0 : pwm_cnt + DUTY_W'(1);
        for (int i = 0; i < CHANNELS; i++) begin
            next_active[i]  = wrap ? shadow[i] : active[i];
            next_pattern[i] = (next_cnt < next_active[i]);
        end
    end

    // Shadow bank: host writes land here one cycle after the strobe.
    // NOTE: the duty banks are small register files, not RAM, and must read
    // as zero after reset, so they are reset entry by entry.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < CHANNELS; i++) begin
                shadow[i] <= '0;
            end
        end else if (wr_en && addr_ok) begin
            shadow[wr_addr] <= wr_data;
        end
    end

    // Frame advance: counter, commit at wrap, registered pattern and pulse.
    // A commit in the same cycle as a write takes the pre-write shadow value
    // because both blocks sample shadow before the edge.
    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the values from before the edge, regardless of block ordering.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            pwm_cnt      <= '0;
            rgb_x4       <= '0;
            period_start <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                active[i] <= '0;
            end
        end else begin
            period_start <= 1'b0;
            if (frame_tick) begin
                pwm_cnt      <= next_cnt;
                rgb_x4       <= next_pattern;
                period_start <= wrap;
                for (int i = 0; i < CHANNELS; i++) begin
                    active[i] <= next_active[i];
                end
            end
        end
    end

    // Out-of-range write flag, valid for the single cycle after the write.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wr_err <= 1'b0;
        end else begin
            wr_err <= wr_en && !addr_ok;
        end
    end

endmodule

// File: tb/tb_led_pwm_frame.sv
// Self-checking bench for led_pwm_frame: directed scenarios plus random
// traffic, every output compared each cycle against a behavioural model.
module tb_led_pwm_frame;

    localparam int CH = 12;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [3:0]  wr_data = '0;
    logic        frame_tick = 1'b0;
    logic [11:0] rgb_x4;
    logic        period_start;
    logic        wr_err;

    led_pwm_frame #(.CHANNELS(CH), .DUTY_W(4)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .frame_tick   (frame_tick),
        .rgb_x4       (rgb_x4),
        .period_start (period_start),
        .wr_err       (wr_err)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: duty tables and the frame index within the period.
    int          m_shadow [CH];
    int          m_active [CH];
    int          m_frame;
    logic [11:0] exp_rgb;
    logic        exp_ps;
    logic        exp_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            m_shadow[i] = 0;
            m_active[i] = 0;
        end
        m_frame = 0;
        exp_rgb = '0;
        exp_ps  = 1'b0;
        exp_err = 1'b0;
    endtask

    // A channel with duty d is lit in frames 0..d-1 of each 16-frame period.
    task automatic model_edge(input logic we, input int a, input int d, input logic t);
        exp_err = we && (a >= CH);
        exp_ps  = 1'b0;
        if (t) begin
            m_frame = (m_frame + 1) % 16;
            if (m_frame == 0) begin
                m_active = m_shadow;
                exp_ps   = 1'b1;
            end
            for (int i = 0; i < CH; i++) begin
                exp_rgb[i] = (m_frame < m_active[i]);
            end
        end
        if (we && a < CH) m_shadow[a] = d;
    endtask

    // One clock: drive inputs, advance the model at the edge, compare after it.
    task automatic step(input logic we, input int a, input int d, input logic t);
        wr_en      = we;
        wr_addr    = 4'(a);
        wr_data    = 4'(d);
        frame_tick = t;
        @(posedge CLK);
        if (!RESET) model_reset();
        else        model_edge(we, a, d, t);
        #1;
        check("rgb_x4", 32'(rgb_x4), 32'(exp_rgb));
        check("period_start", 32'(period_start), 32'(exp_ps));
        check("wr_err", 32'(wr_err), 32'(exp_err));
    endtask

    // One frame: a tick followed by a few idle cycles; reports period_start.
    task automatic tick_frame(output logic ps);
        step(1'b0, 0, 0, 1'b1);
        ps = period_start;
        repeat ($urandom_range(0, 2)) step(1'b0, 0, 0, 1'b0);
    endtask

    task automatic run_to_period_start();
        logic ps;
        bit   seen;
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick_frame(ps);
            seen = ps;
        end
        check("period_start_seen", 32'(seen), 32'd1);
    endtask

    task automatic run_to_frame(input int f);
        logic ps;
        for (int k = 0; k < 20 && m_frame != f; k++) tick_frame(ps);
        check("reach_frame", 32'(m_frame), 32'(f));
    endtask

    initial begin
        logic ps;
        int   cnt;
        int   t_count;
        bit   seen;

        model_reset();

        // Reset held with random activity: outputs stay zero.
        for (int k = 0; k < 8; k++) begin
            step(1'($urandom_range(0, 1)), $urandom_range(0, 15),
                 $urandom_range(0, 15), 1'($urandom_range(0, 1)));
        end
        #2 RESET = 1'b1;

        // 20 ticks with no writes: pattern stays dark.
        for (int k = 0; k < 20; k++) tick_frame(ps);
        check("dark_after_reset", 32'(rgb_x4), 32'h000);

        // Duty pattern ch0=15, ch1=8, ch11=1.
        step(1'b1, 0, 15, 1'b0);
        step(1'b1, 1, 8, 1'b0);
        step(1'b1, 11, 1, 1'b0);
        run_to_period_start();
        check("frame0_pattern", 32'(rgb_x4), 32'h803);
        run_to_frame(8);
        check("frame8_pattern", 32'(rgb_x4), 32'h001);
        run_to_frame(15);
        check("frame15_pattern", 32'(rgb_x4), 32'h000);

        // Double buffering: ch2=15 active, rewritten to 0 at frame 3.
        step(1'b1, 2, 15, 1'b0);
        run_to_period_start();
        run_to_frame(3);
        step(1'b1, 2, 0, 1'b0);
        check("dbuf_bit2_f3", 32'(rgb_x4[2]), 32'd1);
        for (int f = 4; f <= 14; f++) begin
            run_to_frame(f);
            check("dbuf_bit2_hold", 32'(rgb_x4[2]), 32'd1);
        end
        run_to_period_start();
        check("dbuf_bit2_new", 32'(rgb_x4[2]), 32'd0);

        // Write/commit collision on ch5.
        step(1'b1, 5, 4, 1'b0);
        run_to_frame(15);
        step(1'b1, 5, 12, 1'b1);
        check("collide_ps", 32'(period_start), 32'd1);
        cnt = int'(rgb_x4[5]);
        for (int k = 1; k < 16; k++) begin
            tick_frame(ps);
            cnt += int'(rgb_x4[5]);
        end
        check("collide_old_on_frames", 32'(cnt), 32'd4);
        cnt = 0;
        for (int k = 0; k < 16; k++) begin
            tick_frame(ps);
            cnt += int'(rgb_x4[5]);
        end
        check("collide_new_on_frames", 32'(cnt), 32'd12);

        // Bad address: flag pulses one cycle, nothing else changes.
        step(1'b1, 12, 15, 1'b0);
        check("bad_addr_err", 32'(wr_err), 32'd1);
        step(1'b0, 0, 0, 1'b0);
        check("bad_addr_err_clear", 32'(wr_err), 32'd0);
        for (int k = 0; k < 32; k++) tick_frame(ps);

        // Reset mid-period at frame 9 with ch0=15 active.
        run_to_frame(9);
        check("pre_reset_bit0", 32'(rgb_x4[0]), 32'd1);
        #2 RESET = 1'b0;
        #1;
        model_reset();
        check("async_reset_rgb", 32'(rgb_x4), 32'h000);
        step(1'b0, 0, 0, 1'b1);
        step(1'b0, 0, 0, 1'b0);
        #2 RESET = 1'b1;
        t_count = 0;
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick_frame(ps);
            t_count++;
            seen = ps;
        end
        check("ps_tick_after_reset", 32'(t_count), 32'd16);
        check("bit0_cleared", 32'(rgb_x4[0]), 32'd0);

        // Random traffic, including back-to-back ticks and bad addresses.
        for (int k = 0; k < 1500; k++) begin
            step(1'($urandom_range(0, 3) == 0), $urandom_range(0, 15),
                 $urandom_range(0, 15), 1'($urandom_range(0, 3) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/led_pwm_frame.md
# led_pwm_frame

Upstream stage for the TLC6C5912 12-bit LED shift-register serializer. It holds a 4-bit duty value per output channel (12 channels = 4 RGB LEDs) and generates one 12-bit on/off pattern per serializer frame, so the LED brightness becomes a frame-rate PWM. Duty values are double-buffered: writes land in a shadow bank and commit only at a PWM-period boundary, so a period never mixes old and new settings. The pattern is presented on `rgb_x4` and changes only on a frame boundary reported by the serializer.

## Interface
- `CHANNELS`, 12, number of output channels; equals the serializer width.
- `DUTY_W`, 4, duty/PWM counter width; the PWM period is 2^DUTY_W frames.
- `CLK` in 1: single clock, same clock as the serializer.
- `RESET` in 1: asynchronous, active-low reset.
- `wr_en` in 1: shadow duty write strobe, one write per cycle.
- `wr_addr` in 4: channel index, valid range 0..CHANNELS-1.
- `wr_data` in DUTY_W: duty value, 0 = always off, 2^DUTY_W-1 = on for (2^DUTY_W-1)/2^DUTY_W of frames.
- `frame_tick` in 1: single-cycle pulse from the serializer, asserted in the cycle it starts a new 12-bit frame.
- `rgb_x4` out CHANNELS: registered on/off pattern; bit i drives channel i.
- `period_start` out 1: single-cycle pulse marking the first frame of a PWM period.
- `wr_err` out 1: single-cycle pulse for a write to an out-of-range address.

## Operation
- Storage: shadow bank `shadow[CHANNELS]` and active bank `active[CHANNELS]`, each entry DUTY_W bits. There is also a PWM counter `pwm_cnt` of DUTY_W bits.
- Write: when `wr_en` is high and `wr_addr` < CHANNELS, `shadow[wr_addr]` <= `wr_data` at the clock edge. When `wr_en` is high and `wr_addr` >= CHANNELS, no storage changes and `wr_err` = 1 in the next cycle.
- Frame advance, on a `frame_tick` cycle:
  - If `pwm_cnt` == 2^DUTY_W-1 (wrap): `pwm_cnt` <= 0, `active` <= `shadow` (all channels at once), and `period_start` <= 1.
  - Otherwise: `pwm_cnt` <= `pwm_cnt`+1 and `period_start` <= 0.
- Pattern: the pattern is computed from the next `pwm_cnt` value and the active bank as it will be after this tick. It is registered as `rgb_x4[i]` <= (next_cnt < next_active[i]), with an unsigned compare at DUTY_W bits.
- With no `frame_tick`, `rgb_x4`, `pwm_cnt` and `active` hold their values and `period_start` = 0.
- Write and commit in the same cycle:
  - The commit copies the shadow value from before the write.
  - The written value lands in shadow and commits at the following wrap.
  - The commit is never lost and the write is never lost.
- `frame_tick` is treated as a level sample each cycle. Back-to-back ticks advance the counter once per cycle; the block does not detect this as an error.
- Reset (any time, including mid-period): `shadow`, `active` and `pwm_cnt` all go to 0. `rgb_x4`=0, `period_start`=0, `wr_err`=0. The first `frame_tick` after reset advances `pwm_cnt` to 1. That tick is not a wrap, so no commit happens until the 16th tick after reset.

## Timing
- Write to shadow: 1 cycle. Shadow to visible output: at the first wrap tick after the write, plus 1 cycle.
- `rgb_x4` and `period_start` update at the edge ending the `frame_tick` cycle, i.e. they are valid in the cycle after the tick.
- `rgb_x4` is constant between ticks. The serializer needs it stable for its full 12-cycle frame, which this guarantees when ticks are ≥12 cycles apart.
- `wr_err` is valid the cycle after the offending write.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- PWM period = 2^DUTY_W frames. With a 12-cycle frame at 10 MHz this is 192 cycles, giving about 52 kHz.

## Test plan
- Reset: hold `RESET`=0 with random `wr_en`/`frame_tick` toggling. Required: `rgb_x4`=0x000, `period_start`=0 and `wr_err`=0 throughout. After release and 20 ticks with no writes, `rgb_x4` stays 0x000.
- Duty pattern: write ch0=15, ch1=8, ch11=1, then run ticks until `period_start` fires.
  - Over the 16 frames of that period, bit0 is 1 in frames 0-14, bit1 in frames 0-7, and bit11 in frame 0 only.
  - Frame 0 is therefore `rgb_x4`=0x803; frame 8 is 0x001; frame 15 is 0x000.
- Double buffering: with ch2=15 active, write ch2=0 at period frame 3. Required: bit2 stays 1 for frames 3-14 and becomes 0 from the next period's frame 0.
- Write/commit collision: with ch5 shadow=4, write ch5=12 in the same cycle as a wrap tick. Required: the next period shows ch5 on for frames 0-3; the period after shows frames 0-11.
- Bad address: write `wr_addr`=12 with data 15. Required: `wr_err` pulses for 1 cycle, and no channel changes over the following 2 periods.
- Reset mid-period: at frame 9 with ch0=15 active, assert `RESET`. Required: `rgb_x4`=0 immediately. After release, the first `period_start` comes on the 16th tick, and ch0 stays off because shadow was cleared.
